// File: rtl/sjr_mac_method_responder.sv
// Synthesijer-style callee exposing mac(x,y) (iterative shift-add into acc) and clear().
// Optional SJR_MAC_SATURATE_EN: saturating accumulate plus a sticky mac_sat output.
module sjr_mac_method_responder #(
    parameter int WIDTH     = 32,
    parameter int ACC_WIDTH = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [WIDTH-1:0]     mac_x,
    input  logic [WIDTH-1:0]     mac_y,
    input  logic                 mac_req,
    output logic                 mac_busy,
    output logic [ACC_WIDTH-1:0] mac_return,
    input  logic                 clear_req,
    output logic                 clear_busy,
`ifdef SJR_MAC_SATURATE_EN
    output logic                 mac_sat,
`endif
    output logic [ACC_WIDTH-1:0] clear_return
);

    localparam int PROD_W = (ACC_WIDTH > 2*WIDTH) ? ACC_WIDTH : 2*WIDTH;
    localparam int CNT_W  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH-1);

    typedef enum logic [1:0] {IDLE, MUL, ACC, CLR} state_t;

    state_t               state, state_nxt;
    logic                 mac_req_d, clear_req_d;
    logic                 mac_pend, clear_pend;
    logic                 mac_pend_nxt, clear_pend_nxt;
    logic                 mac_edge, clear_edge;
    logic                 mac_active, clear_active;
    logic                 mac_accept;
    logic [WIDTH-1:0]     x_q, y_q;
    logic [PROD_W-1:0]    product;
    logic [CNT_W-1:0]     count;
    logic [ACC_WIDTH-1:0] acc, acc_sum;
`ifdef SJR_MAC_SATURATE_EN
    logic [ACC_WIDTH:0]   wide_sum;
    logic                 prod_ovf;
    logic                 sat_hit;
`endif

    assign mac_edge     = mac_req & ~mac_req_d;
    assign clear_edge   = clear_req & ~clear_req_d;
    assign mac_active   = (state == MUL) || (state == ACC);
    assign clear_active = (state == CLR);
    assign mac_busy     = mac_edge | mac_pend | mac_active;
    assign clear_busy   = clear_edge | clear_pend | clear_active;
    // Arguments are captured when the call is accepted, so a pending mac keeps them.
    assign mac_accept   = mac_edge & ~mac_pend & ~mac_active;

    always_comb begin
        state_nxt      = state;
        mac_pend_nxt   = mac_pend;
        clear_pend_nxt = clear_pend;
        case (state)
            IDLE: begin
                if (clear_edge || clear_pend) begin
                    state_nxt      = CLR;
                    clear_pend_nxt = 1'b0;
                    if (mac_edge) mac_pend_nxt = 1'b1;
                end else if (mac_edge || mac_pend) begin
                    state_nxt    = MUL;
                    mac_pend_nxt = 1'b0;
                end
            end
            MUL: begin
                if (count == CNT_LAST) state_nxt = ACC;
                if (clear_edge) clear_pend_nxt = 1'b1;
            end
            ACC: begin
                state_nxt = IDLE;
                if (clear_edge) clear_pend_nxt = 1'b1;
            end
            CLR: begin
                state_nxt = IDLE;
                if (mac_edge) mac_pend_nxt = 1'b1;
            end
            default: state_nxt = IDLE;
        endcase
    end

`ifdef SJR_MAC_SATURATE_EN
    always_comb begin
        wide_sum = {1'b0, acc} + {1'b0, product[ACC_WIDTH-1:0]};
        prod_ovf = (product >> ACC_WIDTH) != '0;
        sat_hit  = wide_sum[ACC_WIDTH] | prod_ovf;
        acc_sum  = sat_hit ? '1 : wide_sum[ACC_WIDTH-1:0];
    end
`else
    assign acc_sum = acc + product[ACC_WIDTH-1:0];
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            mac_req_d    <= 1'b0;
            clear_req_d  <= 1'b0;
            mac_pend     <= 1'b0;
            clear_pend   <= 1'b0;
            x_q          <= '0;
            y_q          <= '0;
            product      <= '0;
            count        <= '0;
            acc          <= '0;
            mac_return   <= '0;
            clear_return <= '0;
`ifdef SJR_MAC_SATURATE_EN
            mac_sat      <= 1'b0;
`endif
        end else begin
            state       <= state_nxt;
            mac_req_d   <= mac_req;
            clear_req_d <= clear_req;
            mac_pend    <= mac_pend_nxt;
            clear_pend  <= clear_pend_nxt;
            if (mac_accept) begin
                x_q <= mac_x;
                y_q <= mac_y;
            end
            case (state)
                IDLE: begin
                    if (state_nxt == MUL) begin
                        product <= '0;
                        count   <= '0;
                    end
                end
                MUL: begin
                    if (y_q[count]) product <= product + (PROD_W'(x_q) << count);
                    count <= count + 1'b1;
                end
                ACC: begin
                    acc        <= acc_sum;
                    mac_return <= acc_sum;
`ifdef SJR_MAC_SATURATE_EN
                    if (sat_hit) mac_sat <= 1'b1;
`endif
                end
                CLR: begin
                    clear_return <= acc;
                    acc          <= '0;
`ifdef SJR_MAC_SATURATE_EN
                    mac_sat      <= 1'b0;
`endif
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sjr_mac_method_responder.sv
// Scoreboard bench for sjr_mac_method_responder: stimulus pushes expected returns,
// a monitor pops and checks them when the matching busy falls.
module tb_sjr_mac_method_responder;

    logic        clk;
    logic        reset;
    logic [31:0] mac_x, mac_y;
    logic        mac_req, clear_req;
    logic        mac_busy, clear_busy;
    logic [63:0] mac_return, clear_return;
`ifdef SJR_MAC_SATURATE_EN
    logic        mac_sat;
`endif

    sjr_mac_method_responder #(.WIDTH(32), .ACC_WIDTH(64)) dut (
        .clk(clk),
        .reset(reset),
        .mac_x(mac_x),
        .mac_y(mac_y),
        .mac_req(mac_req),
        .mac_busy(mac_busy),
        .mac_return(mac_return),
        .clear_req(clear_req),
        .clear_busy(clear_busy),
`ifdef SJR_MAC_SATURATE_EN
        .mac_sat(mac_sat),
`endif
        .clear_return(clear_return)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] val;
        int          len;
    } exp_t;

    exp_t mac_q[$];
    exp_t clr_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Monitor: a falling busy (not caused by reset) marks a completed call.
    logic mac_prev = 1'b0, clr_prev = 1'b0, rst_prev = 1'b1;
    int   mac_run = 0, clr_run = 0;
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            mac_run = 0;
            clr_run = 0;
        end else begin
            if (mac_busy) mac_run++;
            else begin
                if (mac_prev && !rst_prev) begin
                    if (mac_q.size() == 0) check("mac_unexpected_completion", 64'd1, 64'd0);
                    else begin
                        e = mac_q.pop_front();
                        check("mac_return", mac_return, e.val);
                        if (e.len != 0) check("mac_busy_cycles", 64'(mac_run), 64'(e.len));
                    end
                end
                mac_run = 0;
            end
            if (clear_busy) clr_run++;
            else begin
                if (clr_prev && !rst_prev) begin
                    if (clr_q.size() == 0) check("clear_unexpected_completion", 64'd1, 64'd0);
                    else begin
                        e = clr_q.pop_front();
                        check("clear_return", clear_return, e.val);
                        if (e.len != 0) check("clear_busy_cycles", 64'(clr_run), 64'(e.len));
                    end
                end
                clr_run = 0;
            end
        end
        mac_prev = mac_busy;
        clr_prev = clear_busy;
        rst_prev = reset;
    end

    task automatic issue_mac(input logic [31:0] x, input logic [31:0] y,
                             input logic [63:0] exp, input int len);
        exp_t e;
        mac_x   = x;
        mac_y   = y;
        mac_req = 1'b1;
        e.val = exp;
        e.len = len;
        mac_q.push_back(e);
    endtask

    task automatic issue_clear(input logic [63:0] exp, input int len);
        exp_t e;
        clear_req = 1'b1;
        e.val = exp;
        e.len = len;
        clr_q.push_back(e);
    endtask

    // Drop requests next cycle and scramble arguments to prove they were latched.
    task automatic release_reqs();
        @(posedge clk); #1;
        mac_req   = 1'b0;
        clear_req = 1'b0;
        mac_x     = $urandom;
        mac_y     = $urandom;
    endtask

    task automatic wait_idle(input string name, input int budget);
        bit done = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (!mac_busy && !clear_busy) begin
                done = 1;
                break;
            end
        end
        if (!done) check({name, "_timeout"}, 64'd1, 64'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit clr_seen;
        reset = 1'b1; mac_req = 1'b0; clear_req = 1'b0; mac_x = '0; mac_y = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("reset_mac_return", mac_return, 64'd0);
        check("reset_clear_return", clear_return, 64'd0);
        check("reset_mac_busy", {63'd0, mac_busy}, 64'd0);
        check("reset_clear_busy", {63'd0, clear_busy}, 64'd0);
        @(posedge clk); #1;

        // 1: mac(3,5) -> 15, busy 34 cycles, clear_busy never rises
        issue_mac(32'd3, 32'd5, 64'd15, 34);
        release_reqs();
        clr_seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (clear_busy) clr_seen = 1;
        end
        check("t1_clear_busy_quiet", {63'd0, clr_seen}, 64'd0);
        @(posedge clk); #1;

        // 3: acc=15, clear and mac(2,7) together; clear first, mac pends
        issue_clear(64'd15, 2);
        issue_mac(32'd2, 32'd7, 64'd14, 36);
        @(negedge clk);
        check("t3_both_busy", {62'd0, mac_busy, clear_busy}, 64'd3);
        release_reqs();
        wait_idle("t3", 60);
        issue_clear(64'd14, 2);
        release_reqs();
        wait_idle("t3_clr", 10);

        // 2: wrap-around (or saturation) on large products
        issue_mac(32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 34);
        release_reqs();
        wait_idle("t2a", 50);
`ifdef SJR_MAC_SATURATE_EN
        check("t2_sat_clear_before", {63'd0, mac_sat}, 64'd0);
        issue_mac(32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 34);
        release_reqs();
        wait_idle("t2b", 50);
        check("t2_sat_set", {63'd0, mac_sat}, 64'd1);
        issue_clear(64'hFFFF_FFFF_FFFF_FFFF, 2);
        release_reqs();
        wait_idle("t2c", 10);
        check("t2_sat_cleared", {63'd0, mac_sat}, 64'd0);
`else
        issue_mac(32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFC_0000_0002, 34);
        release_reqs();
        wait_idle("t2b", 50);
        issue_clear(64'hFFFF_FFFC_0000_0002, 2);
        release_reqs();
        wait_idle("t2c", 10);
`endif

        // 4: req held high 200 cycles launches exactly one call
        issue_mac(32'd1, 32'd1, 64'd1, 34);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (i == 40) check("t4_busy_low_while_held", {63'd0, mac_busy}, 64'd0);
            @(posedge clk); #1;
        end
        mac_req = 1'b0;
        wait_idle("t4", 10);
        issue_clear(64'd1, 2);
        release_reqs();
        wait_idle("t4_clr", 10);

        // 5: reset at MUL cycle 10 aborts mac(9,9)
        mac_x = 32'd9; mac_y = 32'd9; mac_req = 1'b1;
        release_reqs();
        repeat (9) begin @(posedge clk); #1; end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("t5_busy_after_reset", {63'd0, mac_busy}, 64'd0);
        check("t5_mac_return_reset", mac_return, 64'd0);
        check("t5_clear_return_reset", clear_return, 64'd0);
        @(posedge clk); #1;
        issue_mac(32'd1, 32'd1, 64'd1, 34);
        release_reqs();
        wait_idle("t5", 50);

        // 6: acc=4, clear edge during mac(2,3) becomes pending
        issue_mac(32'd1, 32'd3, 64'd4, 34);
        release_reqs();
        wait_idle("t6_setup", 50);
        issue_mac(32'd2, 32'd3, 64'd10, 34);
        release_reqs();
        repeat (4) begin @(posedge clk); #1; end
        issue_clear(64'd10, 31);
        @(negedge clk);
        check("t6_clear_busy_on_edge", {63'd0, clear_busy}, 64'd1);
        release_reqs();
        wait_idle("t6", 60);
        issue_mac(32'd1, 32'd1, 64'd1, 34);
        release_reqs();
        wait_idle("t6_after", 50);

        check("mac_queue_drained", 64'(mac_q.size()), 64'd0);
        check("clear_queue_drained", 64'(clr_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sjr_mac_method_responder.md
Name: sjr_mac_method_responder

Overview:
- Hand-written RTL responder for the Synthesijer method-call protocol (per method: `*_req` in, `*_busy` out, argument inputs, `*_return` out).
- Two methods exposed to a generated caller:
  - `mac(x,y)`: acc += x*y via iterative shift-add.
  - `clear()`: returns the old acc, then zeroes it.
- Sits beside Synthesijer-generated modules as a callee, and is exercised by sim_* benches exactly as generated modules are.

Parameters:
- WIDTH, 32, operand width of mac_x / mac_y (unsigned).
- ACC_WIDTH, 64, accumulator and return width; must be >= WIDTH.

Ports:
- clk  in  1  single clock, all state on rising edge.
- reset  in  1  synchronous, active-high.
- mac_x  in  WIDTH  mac argument x, sampled on call accept.
- mac_y  in  WIDTH  mac argument y, sampled on call accept.
- mac_req  in  1  mac call request; a call is launched by its rising edge.
- mac_busy  out  1  high while a mac call is accepted, pending or running.
- mac_return  out  ACC_WIDTH  acc value after the last completed mac; held.
- clear_req  in  1  clear call request; a call is launched by its rising edge.
- clear_busy  out  1  high while a clear call is accepted, pending or running.
- clear_return  out  ACC_WIDTH  acc value before the last completed clear; held.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset values: acc=0, mac_return=0, clear_return=0, state=IDLE, pending flags=0, req edge registers=0.
  - Consequence: a req held high through reset launches one call after release.
- Call launch:
  - Edge = req & ~req_d, per method.
  - busy = edge | pending | method active. busy is combinational from the edge, so the caller sees busy in the same cycle as the launching edge.
  - A held-high req launches exactly one call. A new call needs req low for at least 1 cycle, then high again.
- Re-triggering rules:
  - An edge on a method that is already busy is ignored.
  - An edge on a method while the other method is running sets that method's pending flag. It executes in the first IDLE cycle after the running method completes.
- FSM states: IDLE, MUL, ACC, CLR.
  - IDLE:
    - Clear edge or clear pending -> CLR. Clear has priority.
    - Otherwise mac edge or mac pending -> MUL. Latch x and y, product=0, count=0.
    - If both edges arrive in the same cycle, clear goes first and mac becomes pending.
  - MUL: one bit per cycle, LSB first.
    - If y[count] then product += x<<count.
    - Runs WIDTH cycles, then -> ACC.
  - ACC: acc <= acc + product, taken mod 2^ACC_WIDTH; the product is truncated to ACC_WIDTH. mac_return <= new acc. -> IDLE.
  - CLR: clear_return <= acc; acc <= 0. -> IDLE.
- Latency, mac accepted directly at cycle T:
  - mac_busy is high T..T+WIDTH+1.
  - mac_return is updated at the T+WIDTH+1 edge and is valid with mac_busy low at T+WIDTH+2.
- Latency, clear accepted at cycle T: clear_busy is high at T and T+1; clear_return is valid at T+2.
- Return values hold until that method's next completion. Argument changes after accept have no effect.
- Reset mid-operation: the call is aborted, acc is not updated, pending flags are cleared, and busy is low in the cycle after reset is sampled.

Optional Feature:
- Macro: SJR_MAC_SATURATE_EN.
- Defined:
  - ACC addition saturates at 2^ACC_WIDTH-1 instead of wrapping.
  - A product exceeding ACC_WIDTH bits also saturates.
  - A sticky `mac_sat` output bit (1 bit) is added. It is cleared by reset or a completed clear.
- Undefined: wrap-around arithmetic as above, and no mac_sat port.

Test Plan:
1. Reset, then mac(3,5) edge at cycle T -> mac_busy high for 34 cycles; mac_return=15 at T+34; clear_busy stays 0.
2. From acc=0, mac(0xFFFFFFFF,0xFFFFFFFF) twice -> returns 0xFFFFFFFE00000001, then 0xFFFFFFFC00000002 (wrap). With SJR_MAC_SATURATE_EN -> second return 0xFFFFFFFFFFFFFFFF and mac_sat=1.
3. acc=15; clear and mac(2,7) edges in the same cycle -> clear_return=15 two cycles later; mac then runs and mac_return=14; both busys are high in the accept cycle.
4. mac_req held high for 200 cycles with args (1,1) from acc=0 -> exactly one call; mac_return=1; mac_busy low after cycle 34.
5. mac(9,9) in progress; reset pulsed at cycle 10 of MUL -> busy low the next cycle, mac_return=0, acc=0; a subsequent mac(1,1) returns 1.
6. acc=4; mac(2,3) running; clear edge at MUL cycle 5 -> clear_busy high from that cycle; mac_return=10; clear then executes, clear_return=10; a following mac(1,1) returns 1.
